// File: rtl/sa_cache_4way.sv
// 4-way set-associative, write-back, write-allocate cache with one 32-bit word per line.
// It uses true-LRU ages per set, a single outstanding miss, and reports dirty victims on eviction.
module sa_cache_4way #(
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int TAG_W  = 18,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic [$clog2(SETS)-1:0] i_index,
  input  logic [5:0]              i_offset,
  input  logic [DATA_W-1:0]       dataW,
  input  logic [DATA_W-1:0]       i_memory_line,
  input  logic                    i_memory_response,
  input  logic                    memRW,
  output logic [DATA_W-1:0]       o_data,
  output logic [DATA_W-1:0]       line_data,
  output logic                    cache_miss,
  output logic [DATA_W-1:0]       o_evict_data,
  output logic [31:0]             o_evict_addr,
  output logic                    o_evict
);

  typedef enum logic {LOOKUP, FILL} state_t;
  typedef logic [1:0] way_t;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [1:0]        age      [SETS][WAYS];

  state_t state;
  way_t   fill_way;
  logic   hit;
  way_t   hit_way;
  way_t   victim_way;
  logic   victim_found;
  logic   touch;
  way_t   touch_way;
  logic   [1:0] touch_age;

  // A line is exactly one word, so the byte offset never affects lookup.
  logic unused_offset;
  assign unused_offset = ^i_offset;

  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[i_index][w] && tag_mem[i_index][w] == i_tag) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid[i_index][w]) begin
        victim_found = 1'b1;
        victim_way   = way_t'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[i_index][w] == 2'd3) victim_way = way_t'(w);
      end
    end
  end

  always_comb begin
    touch     = (state == LOOKUP && hit) || (state == FILL && i_memory_response);
    touch_way = (state == FILL) ? fill_way : hit_way;
    touch_age = age[i_index][touch_way];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOOKUP;
      fill_way     <= '0;
      o_data       <= '0;
      line_data    <= '0;
      cache_miss   <= 1'b0;
      o_evict      <= 1'b0;
      o_evict_data <= '0;
      o_evict_addr <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= 2'(w);
      end
    end else begin
      o_evict <= 1'b0;
      // Ways younger than the touched way age by one; the touched way becomes MRU.
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (way_t'(w) == touch_way)
            age[i_index][w] <= 2'd0;
          else if (age[i_index][w] < touch_age)
            age[i_index][w] <= age[i_index][w] + 2'd1;
        end
      end
      case (state)
        LOOKUP: begin
          if (hit) begin
            cache_miss <= 1'b0;
            if (memRW) begin
              dirty[i_index][hit_way] <= 1'b1;
              line_data               <= dataW;
            end else begin
              o_data    <= data_mem[i_index][hit_way];
              line_data <= data_mem[i_index][hit_way];
            end
          end else begin
            cache_miss <= 1'b1;
            state      <= FILL;
            fill_way   <= victim_way;
            if (valid[i_index][victim_way] && dirty[i_index][victim_way]) begin
              o_evict      <= 1'b1;
              o_evict_data <= data_mem[i_index][victim_way];
              o_evict_addr <= {tag_mem[i_index][victim_way], i_index, 6'b000000};
            end
          end
        end
        FILL: begin
          if (i_memory_response) begin
            valid[i_index][fill_way] <= 1'b1;
            dirty[i_index][fill_way] <= memRW;
            cache_miss               <= 1'b0;
            state                    <= LOOKUP;
            if (memRW) begin
              line_data <= dataW;
            end else begin
              o_data    <= i_memory_line;
              line_data <= i_memory_line;
            end
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are meaningful.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOOKUP && hit && memRW)
        data_mem[i_index][hit_way] <= dataW;
      if (state == FILL && i_memory_response) begin
        tag_mem[i_index][fill_way]  <= i_tag;
        data_mem[i_index][fill_way] <= memRW ? dataW : i_memory_line;
      end
    end
  end

endmodule

// File: tb/tb_sa_cache_4way.sv
// Directed-vector bench for sa_cache_4way: a table of single-cycle vectors
// followed by a hand-written sequence covering long memory waits and dirty eviction.
module tb_sa_cache_4way;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic [31:0] i_memory_line;
  logic        i_memory_response;
  logic        memRW;
  logic [31:0] o_data;
  logic [31:0] line_data;
  logic        cache_miss;
  logic [31:0] o_evict_data;
  logic [31:0] o_evict_addr;
  logic        o_evict;

  always #5 clk = ~clk;

  sa_cache_4way dut (
    .clk               (clk),
    .rst               (rst),
    .i_tag             (i_tag),
    .i_index           (i_index),
    .i_offset          (i_offset),
    .dataW             (dataW),
    .i_memory_line     (i_memory_line),
    .i_memory_response (i_memory_response),
    .memRW             (memRW),
    .o_data            (o_data),
    .line_data         (line_data),
    .cache_miss        (cache_miss),
    .o_evict_data      (o_evict_data),
    .o_evict_addr      (o_evict_addr),
    .o_evict           (o_evict)
  );

  typedef struct {
    logic        rst;
    logic        rw;
    logic [17:0] tag;
    logic [7:0]  idx;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] mline;
    logic [31:0] exp_data;
    logic [31:0] exp_line;
    logic        exp_miss;
    logic        exp_evict;
    logic [31:0] exp_edata;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  function automatic vec_t mk(input logic r, input logic rw, input logic [17:0] tag,
                              input logic [7:0] idx, input logic [31:0] wdata,
                              input logic resp, input logic [31:0] mline,
                              input logic [31:0] ed, input logic [31:0] el,
                              input logic em, input logic ee,
                              input logic [31:0] eed, input logic [31:0] eea);
    vec_t v;
    v.rst = r; v.rw = rw; v.tag = tag; v.idx = idx; v.wdata = wdata;
    v.resp = resp; v.mline = mline; v.exp_data = ed; v.exp_line = el;
    v.exp_miss = em; v.exp_evict = ee; v.exp_edata = eed; v.exp_eaddr = eea;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    rst               = v.rst;
    memRW             = v.rw;
    i_tag             = v.tag;
    i_index           = v.idx;
    i_offset          = 6'h15;
    dataW             = v.wdata;
    i_memory_response = v.resp;
    i_memory_line     = v.mline;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input vec_t v, input string name);
    vectors_applied++;
    if (o_data !== v.exp_data) begin
      miscompares++;
      $display("[TB] FAIL %s o_data got %h want %h", name, o_data, v.exp_data);
    end
    if (line_data !== v.exp_line) begin
      miscompares++;
      $display("[TB] FAIL %s line_data got %h want %h", name, line_data, v.exp_line);
    end
    if (cache_miss !== v.exp_miss) begin
      miscompares++;
      $display("[TB] FAIL %s cache_miss got %b want %b", name, cache_miss, v.exp_miss);
    end
    if (o_evict !== v.exp_evict) begin
      miscompares++;
      $display("[TB] FAIL %s o_evict got %b want %b", name, o_evict, v.exp_evict);
    end
    if (v.exp_evict || v.rst) begin
      if (o_evict_data !== v.exp_edata) begin
        miscompares++;
        $display("[TB] FAIL %s o_evict_data got %h want %h", name, o_evict_data, v.exp_edata);
      end
      if (o_evict_addr !== v.exp_eaddr) begin
        miscompares++;
        $display("[TB] FAIL %s o_evict_addr got %h want %h", name, o_evict_addr, v.exp_eaddr);
      end
    end
  endtask

  initial begin
    logic [31:0] cur_data;
    logic [31:0] fill_val;
    vec_t        v;

    // rst rw tag idx wdata resp mline | o_data line miss evict edata eaddr
    vecs.push_back(mk(1,0,18'd0,8'd0,32'h0,0,32'h0,  32'h0,32'h0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd0,8'd0,32'h0,0,32'h0,  32'h0,32'h0,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd0,8'd0,32'h0,1,32'hDEADBEEF, 32'hDEADBEEF,32'hDEADBEEF,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd0,8'd0,32'h0,0,32'h0,  32'hDEADBEEF,32'hDEADBEEF,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,18'd5,8'd3,32'h12345678,0,32'h0, 32'hDEADBEEF,32'hDEADBEEF,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,18'd5,8'd3,32'h12345678,1,32'h0, 32'hDEADBEEF,32'h12345678,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd5,8'd3,32'h0,0,32'h0,  32'h12345678,32'h12345678,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,18'd1,8'd7,32'hAAAA0001,0,32'h0, 32'h12345678,32'h12345678,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,18'd1,8'd7,32'hAAAA0001,1,32'h0, 32'h12345678,32'hAAAA0001,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd7,32'h0,0,32'h0,  32'h12345678,32'hAAAA0001,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd7,32'h0,1,32'h22220002, 32'h22220002,32'h22220002,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd3,8'd7,32'h0,0,32'h0,  32'h22220002,32'h22220002,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd3,8'd7,32'h0,1,32'h33330003, 32'h33330003,32'h33330003,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd4,8'd7,32'h0,0,32'h0,  32'h33330003,32'h33330003,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd4,8'd7,32'h0,1,32'h44440004, 32'h44440004,32'h44440004,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd5,8'd7,32'h0,0,32'h0,  32'h44440004,32'h44440004,1,1,32'hAAAA0001,32'h000041C0));
    vecs.push_back(mk(0,0,18'd5,8'd7,32'h0,0,32'h0,  32'h44440004,32'h44440004,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd5,8'd7,32'h0,1,32'h55550005, 32'h55550005,32'h55550005,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd1,8'd9,32'h0,0,32'h0,  32'h55550005,32'h55550005,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd1,8'd9,32'h0,1,32'h09000001, 32'h09000001,32'h09000001,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd9,32'h0,0,32'h0,  32'h09000001,32'h09000001,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd9,32'h0,1,32'h09000002, 32'h09000002,32'h09000002,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd3,8'd9,32'h0,0,32'h0,  32'h09000002,32'h09000002,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd3,8'd9,32'h0,1,32'h09000003, 32'h09000003,32'h09000003,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd4,8'd9,32'h0,0,32'h0,  32'h09000003,32'h09000003,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd4,8'd9,32'h0,1,32'h09000004, 32'h09000004,32'h09000004,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd1,8'd9,32'h0,0,32'h0,  32'h09000001,32'h09000001,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd6,8'd9,32'h0,0,32'h0,  32'h09000001,32'h09000001,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd6,8'd9,32'h0,1,32'h09000006, 32'h09000006,32'h09000006,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd1,8'd9,32'h0,0,32'h0,  32'h09000001,32'h09000001,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd9,32'h0,0,32'h0,  32'h09000001,32'h09000001,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd2,8'd9,32'h0,1,32'h09000002, 32'h09000002,32'h09000002,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,0,32'h0, 32'h09000002,32'h09000002,1,0,32'h0,32'h0));
    vecs.push_back(mk(1,0,18'd7,8'd20,32'h0,0,32'h0, 32'h0,32'h0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,0,32'h0, 32'h0,32'h0,1,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,1,32'h00000077, 32'h77,32'h77,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,1,32'hFFFFFFFF, 32'h77,32'h77,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,0,32'h0, 32'h77,32'h77,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,18'd7,8'd20,32'hCAFE0000,0,32'h0, 32'h77,32'hCAFE0000,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,18'd7,8'd20,32'h0,0,32'h0, 32'hCAFE0000,32'hCAFE0000,0,0,32'h0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], $sformatf("vec%0d", i));
    end

    // Fill the rest of set 20 with slow memory responses, then force out the dirty tag-7 line.
    cur_data = 32'hCAFE0000;
    for (int t = 8; t <= 10; t++) begin
      fill_val = 32'h20000000 | 32'(t);
      v = mk(0,0,18'(t),8'd20,32'h0,0,32'h0, cur_data,cur_data,1,0,32'h0,32'h0);
      apply_stimulus(v);
      check_output(v, $sformatf("seq_miss_t%0d", t));
      for (int k = 0; k < 3; k++) begin
        apply_stimulus(v);
        check_output(v, $sformatf("seq_wait_t%0d_%0d", t, k));
      end
      v = mk(0,0,18'(t),8'd20,32'h0,1,fill_val, fill_val,fill_val,0,0,32'h0,32'h0);
      apply_stimulus(v);
      check_output(v, $sformatf("seq_fill_t%0d", t));
      cur_data = fill_val;
    end
    v = mk(0,0,18'd11,8'd20,32'h0,0,32'h0, cur_data,cur_data,1,1,32'hCAFE0000,32'h0001C500);
    apply_stimulus(v);
    check_output(v, "seq_dirty_evict");
    v = mk(0,0,18'd11,8'd20,32'h0,0,32'h0, cur_data,cur_data,1,0,32'h0,32'h0);
    apply_stimulus(v);
    check_output(v, "seq_evict_pulse_end");
    v = mk(0,0,18'd11,8'd20,32'h0,1,32'h2000000B, 32'h2000000B,32'h2000000B,0,0,32'h0,32'h0);
    apply_stimulus(v);
    check_output(v, "seq_fill_t11");
    v = mk(0,0,18'd8,8'd20,32'h0,0,32'h0, 32'h20000008,32'h20000008,0,0,32'h0,32'h0);
    apply_stimulus(v);
    check_output(v, "seq_hit_t8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
